// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package dmem_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BRD  = 2'd1,
        BWR  = 2'd2
    } state_t;

    // Requester identity, used by the round-robin priority pointer
    typedef enum logic {
        PORT_C = 1'b0,
        PORT_D = 1'b1
    } port_id_t;

    localparam int         WORD_BYTES = 4;
    localparam logic [3:0] BE_FULL    = 4'hF;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of core, DMA/debug and memory-side signals of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on c_req, d_cmd and d_wdata; responses have no backpressure.
// Modports: slave = the arbiter, master = the requesters plus the memory.
interface dmem_arbiter_if #(
    parameter int ADDR_W      = 32,
    parameter int BURST_LEN_W = 4
);
    logic                   c_req_valid;
    logic                   c_req_ready;
    logic                   c_req_we;
    logic [ADDR_W-1:0]      c_req_addr;
    logic [31:0]            c_req_wdata;
    logic [3:0]             c_req_be;
    logic                   c_rsp_valid;
    logic [31:0]            c_rsp_rdata;

    logic                   d_cmd_valid;
    logic                   d_cmd_ready;
    logic                   d_cmd_we;
    logic [ADDR_W-1:0]      d_cmd_addr;
    logic [BURST_LEN_W-1:0] d_cmd_len;
    logic                   d_wdata_valid;
    logic                   d_wdata_ready;
    logic [31:0]            d_wdata;
    logic                   d_rsp_valid;
    logic [31:0]            d_rsp_rdata;
    logic                   d_done;

    logic [ADDR_W-1:0]      m_wr_addr;
    logic [31:0]            m_wr_data;
    logic [3:0]             m_wr_en;
    logic [ADDR_W-1:0]      m_rd_addr;
    logic [31:0]            m_rd_data;

    modport slave (
        input  c_req_valid, c_req_we, c_req_addr, c_req_wdata, c_req_be,
        output c_req_ready, c_rsp_valid, c_rsp_rdata,
        input  d_cmd_valid, d_cmd_we, d_cmd_addr, d_cmd_len, d_wdata_valid, d_wdata,
        output d_cmd_ready, d_wdata_ready, d_rsp_valid, d_rsp_rdata, d_done,
        output m_wr_addr, m_wr_data, m_wr_en, m_rd_addr,
        input  m_rd_data
    );

    modport master (
        output c_req_valid, c_req_we, c_req_addr, c_req_wdata, c_req_be,
        input  c_req_ready, c_rsp_valid, c_rsp_rdata,
        output d_cmd_valid, d_cmd_we, d_cmd_addr, d_cmd_len, d_wdata_valid, d_wdata,
        input  d_cmd_ready, d_wdata_ready, d_rsp_valid, d_rsp_rdata, d_done,
        input  m_wr_addr, m_wr_data, m_wr_en, m_rd_addr,
        output m_rd_data
    );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter with a one-bit priority pointer.
// Latency: grant is combinational from req_i; pointer updates at the clock edge.
// Backpressure: none; a request simply stays ungranted while the other port wins.
// Ports: clk, rst (sync, active high), req_i[1:0] (bit0 core, bit1 D), advance_i, gnt_o[1:0] one-hot.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);

    port_id_t prio_q;
    port_id_t prio_d;

    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (prio_q == PORT_C) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    // Pointer moves only on a contested grant, so an uncontested port does
    // not lose its turn by being the sole requester.
    always_comb begin
        prio_d = prio_q;
        if (advance_i && (req_i == 2'b11)) begin
            prio_d = (prio_q == PORT_C) ? PORT_D : PORT_C;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= PORT_C;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data memory between core single-word accesses and D-port word bursts.
// Latency: writes commit at the fire edge; read data returns one cycle after issue.
// Backpressure: combinational ready on c_req/d_cmd/d_wdata; bursts stall on d_wdata_valid=0.
// Ports: clk, rst (sync, active high), bus (dmem_arbiter_if.slave).
// Build option: DMEM_ARB_PREEMPT_EN lets the core steal every other burst cycle.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int BURST_LEN_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_BRD  = BRD;
    localparam logic [1:0] S_BWR  = BWR;

    logic [1:0]             state_q, state_d;
    logic [BURST_LEN_W-1:0] beat_q, beat_d;
    logic [BURST_LEN_W-1:0] len_q;
    logic [ADDR_W-1:0]      base_q;
    logic [ADDR_W-1:0]      burst_addr;
    logic                   c_rsp_valid_q, d_rsp_valid_q;
    logic [31:0]            c_rsp_rdata_q, d_rsp_rdata_q;

    logic [1:0] gnt;
    logic       idle, steal, c_fire, c_load, d_cmd_fire;
    logic       brd_go, bwr_go, last_beat;

    assign idle = (state_q == S_IDLE);

    // Arbitration only happens in IDLE; requests are masked elsewhere.
    rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .rst       (rst),
        .req_i     ({bus.d_cmd_valid & idle, bus.c_req_valid & idle}),
        .advance_i (idle),
        .gnt_o     (gnt)
    );

`ifdef DMEM_ARB_PREEMPT_EN
    // A steal is refused the cycle after another steal so the burst always
    // gets at least every second memory slot.
    logic steal_q;

    assign steal = !idle && bus.c_req_valid && !steal_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            steal_q <= 1'b0;
        end else begin
            steal_q <= steal;
        end
    end
`else
    assign steal = 1'b0;
`endif

    assign bus.c_req_ready   = gnt[0] | steal;
    assign bus.d_cmd_ready   = gnt[1];
    assign c_fire            = bus.c_req_valid & bus.c_req_ready;
    assign c_load            = c_fire & ~bus.c_req_we;
    assign d_cmd_fire        = bus.d_cmd_valid & gnt[1];

    assign bus.d_wdata_ready = (state_q == S_BWR) & ~steal;
    assign brd_go            = (state_q == S_BRD) & ~steal;
    assign bwr_go            = bus.d_wdata_ready & bus.d_wdata_valid;
    assign last_beat         = (beat_q == len_q);
    assign bus.d_done        = (brd_go | bwr_go) & last_beat;

    // Modulo-2^ADDR_W; the memory only decodes the low index bits, so a
    // burst that runs off the top simply wraps.
    assign burst_addr = base_q + ADDR_W'(beat_q) * ADDR_W'(WORD_BYTES);

    always_comb begin
        bus.m_wr_addr = burst_addr;
        bus.m_wr_data = bus.d_wdata;
        bus.m_wr_en   = 4'h0;
        bus.m_rd_addr = burst_addr;
        if (c_fire) begin
            bus.m_wr_addr = bus.c_req_addr;
            bus.m_wr_data = bus.c_req_wdata;
            bus.m_rd_addr = bus.c_req_addr;
            if (bus.c_req_we) begin
                bus.m_wr_en = bus.c_req_be;
            end
        end else if (bwr_go) begin
            bus.m_wr_en = BE_FULL;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        if (idle) begin
            if (d_cmd_fire) begin
                state_d = bus.d_cmd_we ? S_BWR : S_BRD;
                beat_d  = '0;
            end
        end else if (brd_go || bwr_go) begin
            if (last_beat) begin
                state_d = S_IDLE;
                beat_d  = '0;
            end else begin
                beat_d  = beat_q + BURST_LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            beat_q        <= '0;
            base_q        <= '0;
            len_q         <= '0;
            c_rsp_valid_q <= 1'b0;
            c_rsp_rdata_q <= '0;
            d_rsp_valid_q <= 1'b0;
            d_rsp_rdata_q <= '0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            if (d_cmd_fire) begin
                base_q <= bus.d_cmd_addr & ~ADDR_W'(WORD_BYTES - 1);
                len_q  <= bus.d_cmd_len;
            end
            c_rsp_valid_q <= c_load;
            if (c_load) begin
                c_rsp_rdata_q <= bus.m_rd_data;
            end
            d_rsp_valid_q <= brd_go;
            if (brd_go) begin
                d_rsp_rdata_q <= bus.m_rd_data;
            end
        end
    end

    assign bus.c_rsp_valid = c_rsp_valid_q;
    assign bus.c_rsp_rdata = c_rsp_rdata_q;
    assign bus.d_rsp_valid = d_rsp_valid_q;
    assign bus.d_rsp_rdata = d_rsp_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a 256-word behavioural memory.
// Latency: n/a.
// Backpressure: n/a.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_init = 1'b1;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(32), .BURST_LEN_W(4)) bus ();

    dmem_arbiter #(.ADDR_W(32), .BURST_LEN_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory attached to the DUT: combinational read, byte-enabled write.
    logic [31:0] mem     [256];
    // Reference image of what memory should hold, kept by the bench.
    logic [31:0] ref_mem [256];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (bus.m_wr_en[b]) mem[bus.m_wr_addr[9:2]][b*8 +: 8] <= bus.m_wr_data[b*8 +: 8];
            end
        end
    end

    assign bus.m_rd_data = mem[bus.m_rd_addr[9:2]];

`ifdef DMEM_ARB_PREEMPT_EN
    localparam int EXP_CORE_WAIT = 0;
`else
    localparam int EXP_CORE_WAIT = 4;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    // Single core access; leaves c_req_valid high so calls run back to back.
    task automatic core_op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] be, input logic [31:0] exp);
        bus.c_req_valid = 1'b1;
        bus.c_req_we    = we;
        bus.c_req_addr  = addr;
        bus.c_req_wdata = wd;
        bus.c_req_be    = be;
        #1;
        chk("c_req_ready", 32'(bus.c_req_ready), 32'd1);
        tick();
        if (we) begin
            ref_mem[addr[9:2]] = merge(ref_mem[addr[9:2]], wd, be);
            chk("c_rsp_valid_after_store", 32'(bus.c_rsp_valid), 32'd0);
        end else begin
            chk("c_rsp_valid_after_load", 32'(bus.c_rsp_valid), 32'd1);
            chk("c_rsp_rdata", bus.c_rsp_rdata, exp);
        end
    endtask

    task automatic check_rsp(input logic [7:0] bidx, inout int rsp_cnt);
        if (bus.d_rsp_valid) begin
            chk("d_rsp_rdata", bus.d_rsp_rdata, ref_mem[bidx + 8'(rsp_cnt)]);
            rsp_cnt++;
        end
    endtask

    // Whole D burst; vpat bit (cycle mod 32) gives d_wdata_valid for writes.
    task automatic do_burst(input logic we, input logic [31:0] base, input logic [3:0] len,
                            input logic [31:0] vpat, input logic [31:0] seed);
        logic [7:0] bidx;
        int         k, rsp_cnt, done_cnt;
        bit         seen_done;
        bidx = base[9:2];
        k = 0; rsp_cnt = 0; done_cnt = 0; seen_done = 0;
        bus.c_req_valid = 1'b0;
        bus.d_cmd_valid = 1'b1;
        bus.d_cmd_we    = we;
        bus.d_cmd_addr  = base;
        bus.d_cmd_len   = len;
        #1;
        chk("d_cmd_ready", 32'(bus.d_cmd_ready), 32'd1);
        chk("cmd_cycle_no_write", 32'(bus.m_wr_en), 32'd0);
        tick();
        bus.d_cmd_valid = 1'b0;
        for (int cyc = 0; cyc < 300 && !seen_done; cyc++) begin
            check_rsp(bidx, rsp_cnt);
            bus.d_wdata_valid = we & vpat[cyc % 32];
            bus.d_wdata       = seed + 32'(k) * 32'h01010101;
            #1;
            if (we) chk("d_wdata_ready", 32'(bus.d_wdata_ready), 32'd1);
            if (bus.d_done) begin
                done_cnt++;
                seen_done = 1;
                chk("d_done_on_last_beat", 32'(k), 32'(len));
            end
            if (we) begin
                if (bus.d_wdata_valid && bus.d_wdata_ready) begin
                    ref_mem[bidx + 8'(k)] = bus.d_wdata;
                    k++;
                end
            end else begin
                k++;
            end
            tick();
        end
        bus.d_wdata_valid = 1'b0;
        check_rsp(bidx, rsp_cnt);
        #1;
        chk("d_done_single_pulse", 32'(bus.d_done), 32'd0);
        chk("d_done_count", 32'(done_cnt), 32'd1);
        chk("burst_beats", 32'(k), 32'(len) + 32'd1);
        chk("d_rsp_count", 32'(rsp_cnt), we ? 32'd0 : 32'(len) + 32'd1);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic core_vs_burst();
        int  fire_cyc, k, done_cnt;
        logic core_fired;
        fire_cyc = -1; k = 0; done_cnt = 0;
        bus.d_cmd_valid = 1'b1;
        bus.d_cmd_we    = 1'b1;
        bus.d_cmd_addr  = 32'h80;
        bus.d_cmd_len   = 4'd3;
        #1;
        chk("pre_cmd_ready", 32'(bus.d_cmd_ready), 32'd1);
        tick();
        bus.d_cmd_valid = 1'b0;
        bus.c_req_valid = 1'b1;
        bus.c_req_we    = 1'b0;
        bus.c_req_addr  = 32'h10;
        for (int cyc = 0; cyc < 20 && !(done_cnt > 0 && fire_cyc >= 0); cyc++) begin
            bus.d_wdata_valid = 1'b1;
            bus.d_wdata       = 32'h5A000000 + 32'(k);
            #1;
            core_fired = bus.c_req_valid & bus.c_req_ready;
            if (core_fired) fire_cyc = cyc;
            if (bus.d_wdata_ready) begin
                ref_mem[8'h20 + 8'(k)] = bus.d_wdata;
                k++;
            end
            if (bus.d_done) done_cnt++;
            tick();
            if (core_fired) begin
                chk("pre_c_rsp_valid", 32'(bus.c_rsp_valid), 32'd1);
                chk("pre_c_rsp_rdata", bus.c_rsp_rdata, ref_mem[8'h04]);
                bus.c_req_valid = 1'b0;
            end
        end
        bus.d_wdata_valid = 1'b0;
        bus.c_req_valid   = 1'b0;
        chk("pre_core_wait", 32'(fire_cyc), 32'(EXP_CORE_WAIT));
        chk("pre_beats", 32'(k), 32'd4);
        chk("pre_done_count", 32'(done_cnt), 32'd1);
        for (int i = 0; i < 4; i++) chk("pre_mem", mem[8'h20 + 8'(i)], 32'h5A000000 + 32'(i));
    endtask

    task automatic rr_test();
        int  g [4];
        int  ng;
        bit  busy;
        ng = 0; busy = 0;
        for (int cyc = 0; cyc < 40 && ng < 4; cyc++) begin
            if (busy) begin
                bus.c_req_valid = 1'b0;
                bus.d_cmd_valid = 1'b0;
                busy = 0;
            end else begin
                bus.c_req_valid = 1'b1; bus.c_req_we = 1'b0; bus.c_req_addr = 32'h0;
                bus.d_cmd_valid = 1'b1; bus.d_cmd_we = 1'b0; bus.d_cmd_addr = 32'h0;
                bus.d_cmd_len   = 4'd0;
            end
            #1;
            chk("rr_one_ready", 32'(bus.c_req_ready & bus.d_cmd_ready), 32'd0);
            if (bus.c_req_ready) begin
                g[ng] = 0; ng++;
            end else if (bus.d_cmd_ready) begin
                g[ng] = 1; ng++; busy = 1;
            end
            tick();
        end
        bus.c_req_valid = 1'b0;
        bus.d_cmd_valid = 1'b0;
        chk("rr_grant_count", 32'(ng), 32'd4);
        for (int i = 0; i < ng; i++) chk("rr_grant_order", 32'(g[i]), 32'(i % 2));
        tick();
        tick();
    endtask

    task automatic reset_mid_burst();
        bus.d_cmd_valid = 1'b1;
        bus.d_cmd_we    = 1'b0;
        bus.d_cmd_addr  = 32'h40;
        bus.d_cmd_len   = 4'd7;
        #1;
        chk("rst_cmd_ready", 32'(bus.d_cmd_ready), 32'd1);
        tick();
        bus.d_cmd_valid = 1'b0;
        tick();
        chk("rst_pre_rsp_valid", 32'(bus.d_rsp_valid), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_d_rsp_valid", 32'(bus.d_rsp_valid), 32'd0);
        chk("rst_c_rsp_valid", 32'(bus.c_rsp_valid), 32'd0);
        #1;
        chk("rst_d_done", 32'(bus.d_done), 32'd0);
        do_burst(1'b0, 32'h100, 4'd1, 32'hFFFFFFFF, 32'h0);
    endtask

    initial begin
        bus.c_req_valid   = 1'b0; bus.c_req_we = 1'b0; bus.c_req_addr = '0;
        bus.c_req_wdata   = '0;   bus.c_req_be = '0;
        bus.d_cmd_valid   = 1'b0; bus.d_cmd_we = 1'b0; bus.d_cmd_addr = '0;
        bus.d_cmd_len     = '0;   bus.d_wdata_valid = 1'b0; bus.d_wdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;

        tbl[0]  = '{1'b1, 32'h00000010, 32'hDEADBEEF, 4'hF,    32'h0};
        tbl[1]  = '{1'b0, 32'h00000010, 32'h0,        4'h0,    32'hDEADBEEF};
        tbl[2]  = '{1'b1, 32'h00000020, 32'hFFFFFFFF, 4'hF,    32'h0};
        tbl[3]  = '{1'b1, 32'h00000022, 32'h11223344, 4'b0101, 32'h0};
        tbl[4]  = '{1'b0, 32'h00000020, 32'h0,        4'h0,    32'hFF22FF44};
        tbl[5]  = '{1'b1, 32'h00000024, 32'h00000000, 4'hF,    32'h0};
        tbl[6]  = '{1'b1, 32'h00000024, 32'hA5A5A5A5, 4'b1010, 32'h0};
        tbl[7]  = '{1'b0, 32'h00000027, 32'h0,        4'h0,    32'hA500A500};
        tbl[8]  = '{1'b0, 32'h00000010, 32'h0,        4'h0,    32'hDEADBEEF};
        tbl[9]  = '{1'b1, 32'hFFFFFFFC, 32'h12345678, 4'hF,    32'h0};
        tbl[10] = '{1'b0, 32'hFFFFFFFC, 32'h0,        4'h0,    32'h12345678};

        tick();
        tick();
        mem_init = 1'b0;
        rst      = 1'b0;
        apply_reset();
        chk("reset_c_rsp_valid", 32'(bus.c_rsp_valid), 32'd0);
        chk("reset_d_rsp_valid", 32'(bus.d_rsp_valid), 32'd0);
        chk("reset_c_rsp_rdata", bus.c_rsp_rdata, 32'd0);
        chk("reset_d_rsp_rdata", bus.d_rsp_rdata, 32'd0);
        chk("reset_d_done", 32'(bus.d_done), 32'd0);
        chk("reset_m_wr_en", 32'(bus.m_wr_en), 32'd0);
        chk("reset_c_req_ready", 32'(bus.c_req_ready), 32'd0);
        chk("reset_d_cmd_ready", 32'(bus.d_cmd_ready), 32'd0);

        // Back-to-back core table, including load-after-store.
        for (int i = 0; i < 11; i++) begin
            core_op(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].exp);
        end
        bus.c_req_valid = 1'b0;
        tick();
        chk("c_rsp_single_pulse", 32'(bus.c_rsp_valid), 32'd0);

        // Gapped write burst 1-0-1-1-1 then read back.
        do_burst(1'b1, 32'h40, 4'd3, 32'hFFFFFFFD, 32'hA0000000);
        for (int i = 0; i < 4; i++) begin
            chk("bwr_mem", mem[8'h10 + 8'(i)], 32'hA0000000 + 32'(i) * 32'h01010101);
        end
        do_burst(1'b0, 32'h43, 4'd3, 32'hFFFFFFFF, 32'h0);

        core_vs_burst();

        apply_reset();
        rr_test();

        reset_mid_burst();

        // Random mix checked against the reference memory image.
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 9) < 7) begin
                core_op(1'($urandom), a, $urandom, 4'($urandom), ref_mem[a[9:2]]);
            end else begin
                do_burst(1'($urandom), a, 4'($urandom_range(0, 15)), $urandom | 32'h1, $urandom);
            end
        end
        bus.c_req_valid = 1'b0;
        tick();
        for (int i = 0; i < 256; i++) begin
            if (mem[i] !== ref_mem[i]) chk("final_mem_image", mem[i], ref_mem[i]);
        end
        chk("final_mem_word0", mem[0], ref_mem[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1);
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single-port-pair data memory (combinational read, byte-enabled synchronous write) between two requesters.
- Port C (core load/store unit) issues single-word accesses.
- Port D (DMA/debug) issues word bursts.
- 2-way round-robin arbitration when both are idle-contending; a burst FSM generates word addresses and byte enables; read data is registered into per-port responses.

Parameters:
- BURST_LEN_W, 4, width of d_cmd_len; burst = d_cmd_len+1 beats (1..16).
- ADDR_W, 32, address width on all ports.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- c_req_valid  in  1  core request valid
- c_req_ready  out  1  core request accepted this cycle
- c_req_we  in  1  1=store, 0=load
- c_req_addr  in  ADDR_W  byte address, [1:0] ignored
- c_req_wdata  in  32  store data
- c_req_be  in  4  store byte enables
- c_rsp_valid  out  1  load data valid
- c_rsp_rdata  out  32  load data
- d_cmd_valid  in  1  burst command valid
- d_cmd_ready  out  1  burst command accepted
- d_cmd_we  in  1  1=burst write, 0=burst read
- d_cmd_addr  in  ADDR_W  burst base byte address, [1:0] ignored
- d_cmd_len  in  BURST_LEN_W  beats minus one
- d_wdata_valid  in  1  write beat valid
- d_wdata_ready  out  1  write beat consumed
- d_wdata  in  32  write beat data (all 4 bytes written)
- d_rsp_valid  out  1  read beat valid
- d_rsp_rdata  out  32  read beat data
- d_done  out  1  one-cycle pulse on the cycle the last beat issues
- m_wr_addr  out  32  to memory write address
- m_wr_data  out  32  to memory write data
- m_wr_en  out  4  to memory byte write enables
- m_rd_addr  out  32  to memory read address
- m_rd_data  in  32  from memory combinational read data

Behaviour:
- FSM states: IDLE, BRD (burst read), BWR (burst write).
- Reset: state=IDLE, beat counter=0, rr pointer favours core.
  - c_rsp_valid=0, d_rsp_valid=0, d_done=0, c_rsp_rdata=0, d_rsp_rdata=0.
  - Memory-side outputs are combinational; m_wr_en=0 whenever no write fires.
- IDLE:
  - Only c_req_valid: c_req_ready=1.
  - Only d_cmd_valid: d_cmd_ready=1.
  - Both: grant the port not granted last. rr pointer updates only on a contested grant.
  - Ready signals depend combinationally on valid and state; at most one ready per cycle.
- Core fire (valid&ready):
  - Store: m_wr_addr=c_req_addr, m_wr_data=c_req_wdata, m_wr_en=c_req_be same cycle; memory updates at that edge.
  - Load: m_rd_addr=c_req_addr; m_rd_data captured at edge; c_rsp_valid=1 with c_rsp_rdata next cycle (latency 1), single-cycle pulse.
  - Back-to-back core requests are accepted every cycle.
- D command fire: latch base address with [1:0] forced to 0, len, and we; beat=0; go to BRD or BWR. No memory access occurs in the fire cycle.
- BRD:
  - Each cycle: m_rd_addr = base + 4*beat. Data registered, so d_rsp_valid is 1 the following cycle.
  - beat increments every cycle.
  - When beat==len: d_done=1, return to IDLE. Final d_rsp_valid appears in the IDLE cycle after.
- BWR:
  - d_wdata_ready=1.
  - When d_wdata_valid=1: write at base + 4*beat with m_wr_en=4'hF, beat increments.
  - Stalls indefinitely while d_wdata_valid=0.
  - Last beat: d_done=1, return to IDLE.
- Address arithmetic: 32-bit modulo 2^32. Memory decodes the low word-index bits only, so bursts wrap within the memory naturally; no range check.
- c_req_ready=0 throughout BRD/BWR (feature off).
- Load-after-store to the same word on consecutive core cycles returns the stored data (write committed at the prior edge).
- rst asserted mid-burst:
  - Next edge: IDLE; remaining beats are abandoned.
  - Any pending c_rsp_valid/d_rsp_valid are cleared and d_done is not issued.
  - Memory contents are untouched beyond beats already written.

Optional Feature:
- Macro: DMEM_ARB_PREEMPT_EN.
- Defined:
  - In BRD/BWR a valid core request gets c_req_ready=1 and owns the memory that cycle.
  - The burst beat does not advance; d_wdata_ready=0 for that cycle.
  - At most 1 of every 2 consecutive burst cycles may be stolen: after a steal, the next cycle the burst has priority.
- Undefined: core is fully blocked during bursts.

Decomposition:
- Package dmem_arb_pkg:
  - state_t enum {IDLE,BRD,BWR}
  - WORD_BYTES=4, BE_FULL=4'hF
  - port-id typedef for rr pointer
- Sub-module rr_arb2: 2-requester round-robin, inputs req[1:0], advance, outputs one-hot gnt.

Test Plan:
- Core store addr 0x10 data 0xDEADBEEF be 4'hF, then load 0x10 -> c_rsp_valid one cycle after load fire, rdata 0xDEADBEEF.
- Core store be 4'b0101 data 0x11223344 over 0xFFFFFFFF at 0x20 -> load returns 0xFF22FF44.
- D burst write base 0x40 len 3, d_wdata_valid gapped 1-0-1-1-1 -> words 0x40..0x4C written in order, d_done exactly once; then D burst read same -> four d_rsp_valid pulses with matching data.
- Core and D both valid from reset every idle cycle -> grants alternate core, D, core, D.
- rst for one cycle at beat 2 of a len=7 read burst -> no d_rsp_valid, d_done never pulses, returns IDLE and accepts a new command next cycle.
- With DMEM_ARB_PREEMPT_EN, core load during a len=3 write burst -> core serviced within 1 cycle, burst completes all 4 beats with correct data.
